// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default pixel width, tag bit positions
// and the tagged-pixel layout {sof, eol, eof, pixel}.
package img_pkg;

    localparam int DATA_W_DEFAULT = 8;

    // Tag bit offsets above the pixel field of a tagged entry
    localparam int TAG_EOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_SOF = 2;
    localparam int TAG_W   = 3;

    localparam int TAGGED_W = DATA_W_DEFAULT + TAG_W;

    typedef struct packed {
        logic                      sof;
        logic                      eol;
        logic                      eof;
        logic [DATA_W_DEFAULT-1:0] pixel;
    } tagged_pixel_t;

    // Width of a tagged entry for an arbitrary pixel width
    function automatic int tagged_width(input int data_w);
        return data_w + TAG_W;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Head entry is read
// combinationally; pops on empty and pushes on full (without pop) are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against occupancy; a full FIFO accepts a push only alongside a pop
    always_comb begin
        empty   = (count == LW'(0));
        full    = (count == LW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Storage array write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= LW'(0);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LW'(1);
            end else begin
                count <= count;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_framer.sv
// Tags an unthrottled pixel stream with frame position, buffers it in a FWFT
// FIFO for a valid/ready sink, and reports drops and completed frames.
module pixel_stream_framer
    import img_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pixel_in,
    input  logic                          valid_in,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          m_eof,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int EW = tagged_width(DATA_W);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_x;
    logic          last_y;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Tag from the pre-increment position and decide push/pop/drop this cycle
    always_comb begin
        wr_entry                   = {EW{1'b0}};
        last_x                     = (x == XW'(IMG_W - 1));
        last_y                     = (y == YW'(IMG_H - 1));
        wr_entry[DATA_W-1:0]       = pixel_in;
        wr_entry[DATA_W + TAG_SOF] = (x == XW'(0)) && (y == YW'(0));
        wr_entry[DATA_W + TAG_EOL] = last_x;
        wr_entry[DATA_W + TAG_EOF] = last_x && last_y;
        pop                        = !empty && m_ready;
        push                       = valid_in && (!full || pop);
        drop                       = valid_in && full && !pop;
    end

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign m_valid = !empty;
    assign m_data  = rd_entry[DATA_W-1:0];
    assign m_sof   = rd_entry[DATA_W + TAG_SOF];
    assign m_eol   = rd_entry[DATA_W + TAG_EOL];
    assign m_eof   = rd_entry[DATA_W + TAG_EOF];

    // Raster position follows every upstream pixel, dropped or not, to stay frame-aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= XW'(0);
            y <= YW'(0);
        end else if (valid_in) begin
            if (last_x) begin
                x <= XW'(0);
                y <= last_y ? YW'(0) : (y + YW'(1));
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Sticky drop flag (a new drop beats a clear) and delivered-frame statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            frame_done <= pop && m_eof;
            if (pop && m_eof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Scoreboard bench for pixel_stream_framer with a 4x2 frame and a 4-deep FIFO.
module tb_pixel_stream_framer;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pixel_in = 8'h00;
    logic          valid_in = 1'b0;
    logic          m_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_sof, m_eol, m_eof, m_valid;
    logic [2:0]    fifo_level;
    logic          overflow, frame_done;
    logic [15:0]   frame_cnt;

    int            total = 0;
    int            bad = 0;
    logic [DW+2:0] q[$];
    int            mlvl = 0;
    int            bx = 0;
    int            by = 0;
    logic          exp_ovf = 1'b0;

    always #5 clk = ~clk;

    pixel_stream_framer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
        .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
        .overflow(overflow), .clr_overflow(clr_overflow),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // One clock of stimulus: pops/compares the scoreboard head when the sink takes it,
    // predicts acceptance, pushes the expected tagged entry, then advances one edge.
    task automatic drive(input logic [DW-1:0] pix, input logic vin, input logic rdy, input logic clr);
        logic          pop_p, acc, s, l, f;
        logic [DW+2:0] e;
        pixel_in = pix; valid_in = vin; m_ready = rdy; clr_overflow = clr;
        total++;
        if (m_valid !== (mlvl > 0)) begin
            bad++; $display("FAIL m_valid: got %b want %b", m_valid, (mlvl > 0));
        end
        if (rdy && m_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++; $display("FAIL pop_order: got pop of %h want no data", m_data);
            end else begin
                e = q.pop_front();
                if ({m_sof, m_eol, m_eof, m_data} !== e) begin
                    bad++;
                    $display("FAIL pop_data: got sof/eol/eof/data %b%b%b/%h want %b%b%b/%h",
                             m_sof, m_eol, m_eof, m_data, e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
                end
            end
        end
        pop_p = rdy && (mlvl > 0);
        acc   = vin && (mlvl < DEPTH || pop_p);
        s = (bx == 0) && (by == 0);
        l = (bx == IMG_W - 1);
        f = l && (by == IMG_H - 1);
        if (acc) q.push_back({s, l, f, pix});
        if (vin && !acc) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        mlvl = mlvl + (acc ? 1 : 0) - (pop_p ? 1 : 0);
        if (vin) begin
            if (bx == IMG_W - 1) begin
                bx = 0;
                by = (by == IMG_H - 1) ? 0 : by + 1;
            end else begin
                bx++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && mlvl > 0; i++) drive(8'h00, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_frame();
        for (int i = 0; i < IMG_W * IMG_H && !(bx == 0 && by == 0); i++)
            drive(8'(8'h60 + i), 1'b1, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 8; i++) begin
            drive(8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
            if (i == 0) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== 8'h10 || m_sof !== 1'b1) begin
                    bad++; $display("FAIL latency1: got v=%b d=%h sof=%b want v=1 d=10 sof=1", m_valid, m_data, m_sof);
                end
            end
        end
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL fd_pulse: got %b want 1", frame_done); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL fcnt1: got %0d want 1", frame_cnt); end
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_once: got %b want 0", frame_done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sf_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) drive(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
        total++; if (m_data !== 8'h10) begin bad++; $display("FAIL bp_hold: got %h want 10", m_data); end
        drive(8'h14, 1'b1, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1 || exp_ovf !== 1'b1) begin bad++; $display("FAIL bp_drop: got %b want 1", overflow); end
        total++; if (fifo_level !== 3'd4 || m_data !== 8'h10) begin
            bad++; $display("FAIL bp_unchanged: got lvl=%0d d=%h want lvl=4 d=10", fifo_level, m_data);
        end
        drain();
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL bp_drain: got %0d want 0", fifo_level); end
        finish_frame();
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL bp_fcnt: got %0d want 2", frame_cnt); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_clr: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) drive(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_full: got %0d want 4", fifo_level); end
        drive(8'h24, 1'b1, 1'b1, 1'b0);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_level: got %0d want 4", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
        total++; if (m_data !== 8'h21) begin bad++; $display("FAIL fpp_head: got %h want 21", m_data); end
        drain();
        finish_frame();
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL fpp_fcnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_geometry_after_drop();
        for (int i = 0; i < 5; i++) drive(8'(8'h30 + i), 1'b1, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) drive(8'(8'h35 + i), 1'b1, 1'b0, 1'b0);
        drive(8'h40, 1'b1, 1'b0, 1'b0);
        drive(8'h41, 1'b1, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL geo_drop: got %b want 1", overflow); end
        for (int i = 0; i < 6; i++) drive(8'(8'h42 + i), 1'b1, 1'b1, 1'b0);
        drain();
        total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL geo_fcnt: got %0d want 5", frame_cnt); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL geo_clr: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        drive(8'h50, 1'b1, 1'b1, 1'b0);
        drive(8'h51, 1'b1, 1'b1, 1'b0);
        drive(8'h52, 1'b1, 1'b0, 1'b0);
        total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL rmf_pre: got %0d want 2", fifo_level); end
        valid_in = 1'b0; m_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL rmf_flush: got v=%b lvl=%0d want v=0 lvl=0", m_valid, fifo_level);
        end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rmf_fcnt: got %0d want 0", frame_cnt); end
        q.delete(); mlvl = 0; bx = 0; by = 0; exp_ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(8'hAA, 1'b1, 1'b0, 1'b0);
        total++; if (m_valid !== 1'b1 || m_data !== 8'hAA || m_sof !== 1'b1) begin
            bad++; $display("FAIL rmf_sof: got v=%b d=%h sof=%b want v=1 d=aa sof=1", m_valid, m_data, m_sof);
        end
        drain();
    endtask

    task automatic test_overflow_clear();
        for (int i = 0; i < 4; i++) drive(8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
        drive(8'h74, 1'b1, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL oc_set: got %b want 1", overflow); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL oc_clear: got %b want 0", overflow); end
        drive(8'h75, 1'b1, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL oc_reset: got %b want 1", overflow); end
        drive(8'h76, 1'b1, 1'b0, 1'b1);
        total++; if (overflow !== 1'b1 || exp_ovf !== 1'b1) begin bad++; $display("FAIL oc_setwins: got %b want 1", overflow); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL oc_clear2: got %b want 0", overflow); end
        drain();
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL oc_drain: got %0d want 0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_full_push_pop();
        test_geometry_after_drop();
        test_reset_mid_frame();
        test_overflow_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_framer.md
Name: pixel_stream_framer

Overview:
- Downstream neighbour of the brightness-reduction stage.
- Consumes its raw pixel/valid stream, which has no backpressure, and tags each pixel with frame position: start-of-frame, end-of-line and end-of-frame.
- Buffers tagged pixels in a small FIFO and presents them on a valid/ready stream to the frame writer / display sink.
- Provides the elastic decoupling the brightness stage lacks and flags any data loss.

Parameters:
IMG_W, 256, pixels per line (≥2)
IMG_H, 256, lines per frame (≥1)
FIFO_DEPTH, 16, FIFO entries; power of 2, ≥2
DATA_W, 8, pixel width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pixel_in  in  DATA_W  pixel from brightness stage
valid_in  in  1  pixel_in valid this cycle; no ready path upstream
m_data  out  DATA_W  head-of-FIFO pixel
m_sof  out  1  head pixel is (x=0,y=0)
m_eol  out  1  head pixel is x=IMG_W-1
m_eof  out  1  head pixel is last of frame
m_valid  out  1  FIFO non-empty
m_ready  in  1  sink accepts head when m_valid&&m_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a pixel was dropped
clr_overflow  in  1  synchronous clear of overflow
frame_done  out  1  one-cycle pulse after eof pixel is popped
frame_cnt  out  16  frames fully delivered, wraps at 65535→0

Behaviour:
- Reset (async, rst=1):
  - x=0, y=0; FIFO empty with rd/wr pointers 0 and fifo_level=0.
  - m_valid=0, overflow=0, frame_done=0, frame_cnt=0.
  - m_data/m_sof/m_eol/m_eof are don't-care while m_valid=0.
  - Mid-frame reset discards FIFO contents and position; the next valid_in pixel is treated as sof.
- Position counters:
  - Advance only on valid_in=1.
  - x increments; at x=IMG_W-1 it wraps to 0 and y increments.
  - At y=IMG_H-1 with x=IMG_W-1, y wraps to 0.
  - Counters advance even when the pixel is dropped, so geometry stays aligned to the upstream stream.
- Tags, computed from pre-increment x/y:
  - sof = x==0 && y==0
  - eol = x==IMG_W-1
  - eof = eol && y==IMG_H-1
- FIFO entry = {sof,eol,eof,pixel}, width DATA_W+3.
- Push and pop:
  - Push when valid_in && (fifo_level<FIFO_DEPTH || pop).
  - pop = m_valid && m_ready.
  - Simultaneous push and pop while full is legal; level is unchanged.
  - Pop while empty is ignored.
- Drop: valid_in while full with no pop leaves the FIFO unchanged and sets overflow at the next edge.
- overflow:
  - Cleared by clr_overflow.
  - If set and clear occur in the same cycle, set wins.
- Output is first-word-fall-through:
  - m_valid = fifo_level!=0.
  - m_data and tags are read combinationally from the array at rd_ptr.
  - A pixel pushed at edge N is visible on m_* in cycle N+1 when the FIFO was empty (latency 1).
- m_data and tags must hold stable while m_valid && !m_ready.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_level is a separate counter: +1 push only, −1 pop only, unchanged for both or neither.
- Frame completion: on a pop with m_eof=1, frame_done=1 for exactly the next cycle and frame_cnt increments on that same edge.
- Dropped eof pixel: produces no frame_done and no frame_cnt increment.

Decomposition:
- Shared package img_pkg: DATA_W default, tag bit-index constants (TAG_SOF, TAG_EOL, TAG_EOF), and the tagged-pixel struct/width constant, reused by other image stages.
- One sub-module, sync_fifo_fwft: parameterised by width/depth, with push, pop, full, empty, level and rd_data. The framer owns the counters, tagging, overflow and frame statistics.

Test Plan:
Bench parameters: IMG_W=4, IMG_H=2, FIFO_DEPTH=4.
1. Single frame: 8 pixels 0x10..0x17 with m_ready=1 → m_sof on 0x10; m_eol on 0x13 and 0x17; m_eof on 0x17 only; frame_done pulse one cycle after 0x17 popped; frame_cnt=1; overflow=0.
2. Backpressure: m_ready=0 while 4 pixels pushed → fifo_level=4, m_data holds 0x10. Then 5th pixel 0x14 → dropped, overflow=1. Then m_ready=1 → pops 0x10..0x13 in order.
3. Full with push and pop: level=4, valid_in=1 and m_ready=1 in the same cycle → level stays 4, no overflow, new pixel enters at tail.
4. Geometry after drop: drop pixel at x=1,y=0, continue stream → next delivered eol still on the pixel sent at x=3; eof on the 8th pixel sent.
5. Reset mid-frame: after 3 pixels with FIFO holding 2, assert rst → m_valid=0, level=0. After release, first pixel 0xAA carries m_sof=1.
6. Overflow clear: overflow=1, pulse clr_overflow → 0 next cycle. Clear coincident with a drop → stays 1.
